// File: rtl/lt16_soc_pkg.sv
// rtl/lt16_soc_pkg.sv - shared widths and pin indices for the LT16 demo SoC
// Purpose: board pin widths, button/switch bit positions and prescaler width.
// Ports: none (package).
package lt16_soc_pkg;

    localparam int BTN_W   = 5;
    localparam int SW_W    = 17;
    localparam int LED_W   = 8;
    localparam int PRESC_W = 16;

    // btn[4] is reserved, so only the low four buttons are synchronized.
    localparam int BTN_USED_W = 4;

    localparam int BTN_CLR   = 0;
    localparam int BTN_PAUSE = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_LOAD  = 3;

    localparam int SW_LEDSEL = 16;

endpackage

// File: rtl/lt16_prescaler.sv
// rtl/lt16_prescaler.sv - programmable divide-by-N tick generator
// Purpose: emits a registered one-cycle tick every div cycles; div==0 stops it.
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset
//   clr  in   forces count to 0 and suppresses the tick
//   en   in   0 holds the count (pause), no tick
//   div  in   divisor N
//   tick out  registered one-cycle tick
module lt16_prescaler
    import lt16_soc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic [PRESC_W-1:0] div,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt_q, cnt_d;
    logic               tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr || div == '0) begin
            cnt_d = '0;
        end else if (en) begin
            // >= rather than == so lowering the divisor below the current
            // count terminates the period at once instead of wrapping.
            if (cnt_q >= div - 16'd1) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/lt16_soc_top.sv
// rtl/lt16_soc_top.sv - LT16 demo SoC board top: prescaled 8-bit LED counter
// Purpose: synchronizes buttons/switches, runs a prescaled up/down counter
//          with clear/load/pause, and drives LEDs from counter or switches.
// Ports:
//   clk_sys in   system clock
//   rst     in   synchronous active-high reset
//   btn     in   [4:0] buttons (0 clear, 1 pause, 2 down, 3 load, 4 reserved)
//   sw      in   [16:0] switches ([15:0] divisor, [7:0] load value, [16] LED select)
//   led     out  [7:0] registered LED drive
module lt16_soc_top
    import lt16_soc_pkg::*;
#(
    parameter logic RST_ACTIVE_HIGH = 1'b1
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic [BTN_W-1:0] btn,
    input  logic [SW_W-1:0]  sw,
    output logic [LED_W-1:0] led
);

    if (RST_ACTIVE_HIGH != 1'b1) begin : g_rst_polarity_check
        $error("lt16_soc_top: RST_ACTIVE_HIGH must be 1");
    end

    logic btn_unused;
    assign btn_unused = btn[BTN_W-1];

    logic [BTN_USED_W-1:0] btn_m_q, btn_s_q;
    logic [SW_W-1:0]       sw_m_q, sw_s_q;
    logic [LED_W-1:0]      counter_q, counter_d;
    logic [LED_W-1:0]      led_q, led_d;
    logic                  tick;

    lt16_prescaler u_prescaler (
        .clk  (clk_sys),
        .rst  (rst),
        .clr  (btn_s_q[BTN_CLR]),
        .en   (~btn_s_q[BTN_PAUSE]),
        .div  (sw_s_q[PRESC_W-1:0]),
        .tick (tick)
    );

    // Priority: clear, load, pause, tick. Load discards a coincident tick.
    always_comb begin
        counter_d = counter_q;
        if (btn_s_q[BTN_CLR]) begin
            counter_d = '0;
        end else if (btn_s_q[BTN_LOAD]) begin
            counter_d = sw_s_q[LED_W-1:0];
        end else if (btn_s_q[BTN_PAUSE]) begin
            counter_d = counter_q;
        end else if (tick) begin
            counter_d = btn_s_q[BTN_DOWN] ? counter_q - 8'd1 : counter_q + 8'd1;
        end
    end

    always_comb begin
        led_d = sw_s_q[SW_LEDSEL] ? sw_s_q[LED_W-1:0] : counter_q;
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            btn_m_q   <= '0;
            btn_s_q   <= '0;
            sw_m_q    <= '0;
            sw_s_q    <= '0;
            counter_q <= '0;
            led_q     <= '0;
        end else begin
            btn_m_q   <= btn[BTN_USED_W-1:0];
            btn_s_q   <= btn_m_q;
            sw_m_q    <= sw;
            sw_s_q    <= sw_m_q;
            counter_q <= counter_d;
            led_q     <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_lt16_soc_top.sv
// tb/tb_lt16_soc_top.sv - directed scoreboard bench for lt16_soc_top
module tb_lt16_soc_top;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic [4:0]  btn;
    logic [16:0] sw;
    logic [7:0]  led;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    string      tag_q[$];

    lt16_soc_top #(.RST_ACTIVE_HIGH(1'b1)) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .btn     (btn),
        .sw      (sw),
        .led     (led)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic expect_led(input logic [7:0] v, input string tag);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic check_led();
        logic [7:0] e;
        string      t;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty: led=%02h expected=none", led);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            total++;
            assert (led === e) else begin
                bad++;
                $error("FAIL %s: led=%02h expected=%02h", t, led, e);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        btn = 5'($urandom);
        sw  = 17'($urandom);

        // Reset held for 5 cycles with arbitrary inputs.
        for (int i = 0; i < 5; i++) begin
            expect_led(8'h00, "reset_hold");
            step(1);
            check_led();
            btn = 5'($urandom);
            sw  = 17'($urandom);
        end
        rst = 1'b0;
        btn = 5'b0;
        sw  = 17'h0;
        expect_led(8'h00, "post_reset_a");
        expect_led(8'h00, "post_reset_b");
        step(3);  check_led();
        step(5);  check_led();

        // Count up, divisor 15: first tick reaches led 19 cycles after the pin change.
        sw = 17'h0000F;
        expect_led(8'h00, "up_before_tick");
        expect_led(8'h01, "up_first");
        expect_led(8'h01, "up_hold");
        expect_led(8'h02, "up_second");
        expect_led(8'h0A, "up_ten");
        expect_led(8'hFF, "up_ff");
        expect_led(8'h00, "up_wrap");
        step(18);   check_led();
        step(1);    check_led();
        step(14);   check_led();
        step(1);    check_led();
        step(120);  check_led();
        step(3675); check_led();
        step(15);   check_led();

        // Divisor 0 stops the prescaler.
        sw = 17'h0;
        expect_led(8'h00, "stop_a");
        expect_led(8'h00, "stop_b");
        step(30); check_led();
        step(30); check_led();

        // Divisor 1 while paused: frozen; release counts every cycle.
        sw  = 17'h00001;
        btn = 5'b00010;
        expect_led(8'h00, "pause_frozen");
        step(20); check_led();
        btn = 5'b00000;
        expect_led(8'h00, "unpause_latency");
        expect_led(8'h01, "unpause_1");
        expect_led(8'h02, "unpause_2");
        expect_led(8'h05, "unpause_5");
        step(4); check_led();
        step(1); check_led();
        step(1); check_led();
        step(3); check_led();

        // Clear then count down with divisor 3: wraps to 0xFF, then 0xFE.
        btn = 5'b00101;
        sw  = 17'h00003;
        expect_led(8'h00, "clear_held");
        step(6); check_led();
        btn = 5'b00100;
        expect_led(8'h00, "down_before_tick");
        expect_led(8'hFF, "down_wrap");
        expect_led(8'hFF, "down_hold");
        expect_led(8'hFE, "down_second");
        step(6); check_led();
        step(1); check_led();
        step(2); check_led();
        step(1); check_led();

        // Load, load held against ticks, load while paused, clear beats load.
        btn = 5'b01000;
        sw  = 17'h0005A;
        expect_led(8'h5A, "load");
        expect_led(8'h5A, "load_held");
        step(4);  check_led();
        step(10); check_led();
        btn = 5'b01010;
        sw  = 17'h000C3;
        expect_led(8'hC3, "load_paused");
        step(4); check_led();
        btn = 5'b01001;
        expect_led(8'h00, "clear_beats_load");
        step(4); check_led();

        // Switch LED source: 3 cycles pin to led.
        btn = 5'b00000;
        sw  = 17'h100A5;
        expect_led(8'hA5, "led_mux");
        step(3); check_led();

        // Reset mid-run with divisor 1, then restart from 0.
        sw = 17'h00001;
        step(10);
        rst = 1'b1;
        expect_led(8'h00, "midrun_reset_1");
        expect_led(8'h00, "midrun_reset_2");
        step(1); check_led();
        step(1); check_led();
        rst = 1'b0;
        expect_led(8'h00, "restart_latency");
        expect_led(8'h01, "restart_1");
        expect_led(8'h02, "restart_2");
        step(4); check_led();
        step(1); check_led();
        step(1); check_led();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
